// File: rtl/fft4_s2p_buf.sv
// ---------------------------------------------------------------------------
// fft4_s2p_buf
// Serial-to-parallel buffer feeding a 4-point FFT. Complex samples arrive one
// per accepted cycle. Three shadow slots (A..C) collect the first three
// samples of a block. The fourth sample loads the parallel output registers
// together with the shadow slots on the same edge. The outputs then hold that
// block until the next one completes.
//
// i_sof marks the first sample of a block and is only used to resynchronise.
// Blocks form on their own after reset. If i_sof arrives while a block is
// partly filled, the partial block is dropped and o_sync_err pulses.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset (overrides en)
//   en                clock enable; all state holds while low
//   i_valid           serial sample present
//   i_sof             first sample of a block (qualified by i_valid)
//   i_re, i_im        serial complex sample, DW-bit signed
//   o_reA..o_reD      parallel real parts, A oldest .. D newest
//   o_imA..o_imD      parallel imaginary parts
//   o_valid           one-cycle pulse when a new block is on the outputs
//   o_sync_err        one-cycle pulse when a partial block is discarded
//   o_blk_cnt         completed-block counter, wraps 255 -> 0
// ---------------------------------------------------------------------------
module fft4_s2p_buf #(
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 i_valid,
  input  logic                 i_sof,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic signed [DW-1:0] o_reA,
  output logic signed [DW-1:0] o_reB,
  output logic signed [DW-1:0] o_reC,
  output logic signed [DW-1:0] o_reD,
  output logic signed [DW-1:0] o_imA,
  output logic signed [DW-1:0] o_imB,
  output logic signed [DW-1:0] o_imC,
  output logic signed [DW-1:0] o_imD,
  output logic                 o_valid,
  output logic                 o_sync_err,
  output logic [7:0]           o_blk_cnt
);

  // Shadow slots for the first three samples of the block being collected.
  logic signed [DW-1:0] sh_reA, sh_reB, sh_reC;
  logic signed [DW-1:0] sh_imA, sh_imB, sh_imC;
  logic [1:0]           wp;

  logic accept;
  assign accept = en & i_valid;

  // NOTE: the state below uses non-blocking assignments, so every read in this
  // block sees the value from before the edge. For example, wp in the
  // sync-error test is the pointer as it was before the sof sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow slots are reset too, not only wp. They are few
      // registers, and this way the whole datapath starts in a known state
      // after reset.
      sh_reA     <= '0;
      sh_reB     <= '0;
      sh_reC     <= '0;
      sh_imA     <= '0;
      sh_imB     <= '0;
      sh_imC     <= '0;
      wp         <= 2'd0;
      o_reA      <= '0;
      o_reB      <= '0;
      o_reC      <= '0;
      o_reD      <= '0;
      o_imA      <= '0;
      o_imB      <= '0;
      o_imC      <= '0;
      o_imD      <= '0;
      o_valid    <= 1'b0;
      o_sync_err <= 1'b0;
      o_blk_cnt  <= 8'd0;
    end else begin
      // Both flags are one-cycle pulses. They drop on every edge unless set
      // below. With en low nothing is accepted, so they read 0.
      o_valid    <= 1'b0;
      o_sync_err <= 1'b0;

      if (accept) begin
        if (i_sof) begin
          // Resync: restart the block in slot A and drop any partial block.
          sh_reA     <= i_re;
          sh_imA     <= i_im;
          wp         <= 2'd1;
          o_sync_err <= (wp != 2'd0);
        end else if (wp == 2'd3) begin
          // The fourth sample goes straight to D. No shadow slot is needed.
          o_reA     <= sh_reA;
          o_reB     <= sh_reB;
          o_reC     <= sh_reC;
          o_reD     <= i_re;
          o_imA     <= sh_imA;
          o_imB     <= sh_imB;
          o_imC     <= sh_imC;
          o_imD     <= i_im;
          wp        <= 2'd0;
          o_valid   <= 1'b1;
          o_blk_cnt <= o_blk_cnt + 8'd1;
        end else begin
          case (wp)
            2'd0: begin
              sh_reA <= i_re;
              sh_imA <= i_im;
            end
            2'd1: begin
              sh_reB <= i_re;
              sh_imB <= i_im;
            end
            default: begin
              sh_reC <= i_re;
              sh_imC <= i_im;
            end
          endcase
          wp <= wp + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft4_s2p_buf.sv
// ---------------------------------------------------------------------------
// tb_fft4_s2p_buf
// Directed bench for fft4_s2p_buf. Each expected value is written out by hand.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so each check sees the result of the edge that just passed.
// ---------------------------------------------------------------------------
module tb_fft4_s2p_buf;

  localparam int DW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 i_valid;
  logic                 i_sof;
  logic signed [DW-1:0] i_re;
  logic signed [DW-1:0] i_im;
  logic signed [DW-1:0] o_reA, o_reB, o_reC, o_reD;
  logic signed [DW-1:0] o_imA, o_imB, o_imC, o_imD;
  logic                 o_valid;
  logic                 o_sync_err;
  logic [7:0]           o_blk_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fft4_s2p_buf #(.DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .i_re       (i_re),
    .i_im       (i_im),
    .o_reA      (o_reA),
    .o_reB      (o_reB),
    .o_reC      (o_reC),
    .o_reD      (o_reD),
    .o_imA      (o_imA),
    .o_imB      (o_imB),
    .o_imC      (o_imC),
    .o_imD      (o_imD),
    .o_valid    (o_valid),
    .o_sync_err (o_sync_err),
    .o_blk_cnt  (o_blk_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one valid sample for one cycle. i_valid stays high afterwards,
  // so calls placed back to back stream without gaps.
  task automatic send(input int re, input int im, input logic sof);
    i_valid = 1'b1;
    i_sof   = sof;
    i_re    = 8'(re);
    i_im    = 8'(im);
    tick();
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_sof   = 1'b0;
    tick();
  endtask

  task automatic check_re(input string tag, input int a, input int b,
                          input int c, input int d);
    check({tag, " reA"}, int'(o_reA), a);
    check({tag, " reB"}, int'(o_reB), b);
    check({tag, " reC"}, int'(o_reC), c);
    check({tag, " reD"}, int'(o_reD), d);
  endtask

  int           pulses;
  int           last_pulse;
  int           gap_err;
  logic [7:0]   b8;

  initial begin
    rst = 1'b1; en = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_re = '0; i_im = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_re("reset", 0, 0, 0, 0);
    check("reset imA", int'(o_imA), 0);
    check("reset valid", int'(o_valid), 0);
    check("reset err", int'(o_sync_err), 0);
    check("reset cnt", int'(o_blk_cnt), 0);

    // Basic block 3,2,1,3 with no sof
    send(3, 0, 0);
    send(2, 0, 0);
    send(1, 0, 0);
    check("basic pre valid", int'(o_valid), 0);
    send(3, 0, 0);
    check("basic valid", int'(o_valid), 1);
    check_re("basic", 3, 2, 1, 3);
    check("basic imD", int'(o_imD), 0);
    check("basic cnt", int'(o_blk_cnt), 1);
    idle();
    check("basic valid drop", int'(o_valid), 0);
    check("basic hold reC", int'(o_reC), 1);

    // Signed extremes, i_valid toggling
    send(-128, 127, 0); idle();
    send(127, -128, 0); idle();
    send(-1, 0, 0);     idle();
    check("gap no early valid", int'(o_valid), 0);
    send(0, -1, 0);
    check("gap valid", int'(o_valid), 1);
    check_re("gap", -128, 127, -1, 0);
    check("gap imA", int'(o_imA), 127);
    check("gap imB", int'(o_imB), -128);
    check("gap imD", int'(o_imD), -1);
    check("gap cnt", int'(o_blk_cnt), 2);
    idle();

    // Resync: two samples, then sof mid-block
    send(10, 0, 0);
    send(11, 0, 0);
    send(5, 9, 1);
    check("sync err", int'(o_sync_err), 1);
    check("sync no valid", int'(o_valid), 0);
    check("sync hold reA", int'(o_reA), -128);
    check("sync hold cnt", int'(o_blk_cnt), 2);
    send(6, 0, 0);
    check("sync err drop", int'(o_sync_err), 0);
    send(7, 0, 0);
    send(8, 0, 0);
    check("sync valid", int'(o_valid), 1);
    check_re("sync", 5, 6, 7, 8);
    check("sync imA", int'(o_imA), 9);
    check("sync cnt", int'(o_blk_cnt), 3);
    // sof right on a block boundary is not an error
    send(20, 0, 1);
    check("sof aligned err", int'(o_sync_err), 0);
    send(21, 0, 0);
    send(22, 0, 0);
    send(23, 0, 0);
    check_re("aligned", 20, 21, 22, 23);
    check("aligned cnt", int'(o_blk_cnt), 4);

    // Clock-enable hold between the 2nd and 3rd samples
    send(40, 0, 0);
    send(41, 0, 0);
    en = 1'b0;
    send(99, 99, 0);
    send(99, 99, 1);
    send(99, 99, 0);
    check("en hold valid", int'(o_valid), 0);
    check("en hold err", int'(o_sync_err), 0);
    check("en hold reA", int'(o_reA), 20);
    check("en hold cnt", int'(o_blk_cnt), 4);
    en = 1'b1;
    send(42, 0, 0);
    send(43, 0, 0);
    check("en valid", int'(o_valid), 1);
    check_re("en", 40, 41, 42, 43);
    check("en cnt", int'(o_blk_cnt), 5);
    idle();

    // Reset, then 1024 continuous samples to force the counter to wrap
    rst = 1'b1; tick(); rst = 1'b0;
    check("stream start cnt", int'(o_blk_cnt), 0);
    pulses = 0; last_pulse = -1; gap_err = 0;
    for (int i = 0; i < 1024; i++) begin
      b8 = 8'(i);
      send(int'($signed(b8)), int'($signed(~b8)), 0);
      if (o_valid) begin
        if (i % 4 != 3) gap_err++;
        if (last_pulse >= 0 && i - last_pulse != 4) gap_err++;
        last_pulse = i;
        pulses++;
      end
    end
    check("stream pulses", pulses, 256);
    check("stream spacing", gap_err, 0);
    check("stream cnt wrap", int'(o_blk_cnt), 0);
    check_re("stream last", -4, -3, -2, -1);
    check("stream imA", int'(o_imA), 3);
    idle();
    check("stream valid drop", int'(o_valid), 0);

    // Reset mid-block (with en low: reset wins)
    send(1, 1, 0);
    send(2, 2, 0);
    send(3, 3, 0);
    rst = 1'b1; en = 1'b0; i_valid = 1'b0;
    tick();
    rst = 1'b0; en = 1'b1;
    check_re("midrst", 0, 0, 0, 0);
    check("midrst imA", int'(o_imA), 0);
    check("midrst cnt", int'(o_blk_cnt), 0);
    check("midrst valid", int'(o_valid), 0);
    send(7, 1, 0);
    send(8, 2, 0);
    send(9, 3, 0);
    check("midrst no early", int'(o_valid), 0);
    send(10, 4, 0);
    check("midrst valid2", int'(o_valid), 1);
    check_re("midrst blk", 7, 8, 9, 10);
    check("midrst imA2", int'(o_imA), 1);
    check("midrst cnt2", int'(o_blk_cnt), 1);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft4_s2p_buf.md
FFT4_S2P_BUF -- requirements
Module: fft4_s2p_buf

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the signed width of each real and imaginary sample.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 Port en SHALL be an input, 1 bit: clock enable; when low, all state SHALL hold.
REQ-005 Port i_valid SHALL be an input, 1 bit: a serial sample is present this cycle.
REQ-006 Port i_sof SHALL be an input, 1 bit: the current sample is the first of a 4-sample block; qualified by i_valid.
REQ-007 Ports i_re and i_im SHALL be inputs, DW bits signed each: the serial complex sample.
REQ-008 Ports o_reA, o_reB, o_reC, o_reD and o_imA, o_imB, o_imC, o_imD SHALL be outputs, DW bits signed each: parallel block to the 4-point FFT, where A is the oldest sample and D the newest.
REQ-009 Port o_valid SHALL be an output, 1 bit: pulses high for one cycle when a new block appears on the outputs.
REQ-010 Port o_sync_err SHALL be an output, 1 bit: pulses high for one cycle when a partial block is discarded.
REQ-011 Port o_blk_cnt SHALL be an output, 8 bits: count of completed blocks.

Function
REQ-012 A sample SHALL be accepted on a rising edge only when rst=0, en=1 and i_valid=1.
REQ-013 A 2-bit write pointer wp (0..3) SHALL select the shadow slot (A..C) for the accepted sample.
REQ-014 On acceptance with i_sof=0 and wp<3, the sample SHALL be written to slot wp, and wp SHALL increment.
REQ-015 On acceptance with i_sof=0 and wp=3, on the same edge: all eight outputs SHALL load shadow A..C plus the current sample as D, wp SHALL return to 0, and o_blk_cnt SHALL increment.
REQ-016 o_valid SHALL be 1 in exactly the cycle following the REQ-015 edge, and 0 in all other cycles; latency from the 4th accepted sample SHALL be 1 clock.
REQ-017 On acceptance with i_sof=1, the sample SHALL be written to slot A and wp SHALL be set to 1, regardless of the previous wp.
REQ-018 If i_sof=1 is accepted while wp≠0, the partial block SHALL be discarded, the outputs SHALL NOT change, and o_sync_err SHALL be 1 for the next cycle only.
REQ-019 If i_sof=1 is accepted while wp=0, no error SHALL be flagged.
REQ-020 Blocks SHALL be formed without any i_sof after reset; i_sof is only a resynchronisation mark.
REQ-021 The outputs SHALL hold the last completed block until the next completion, so the downstream stage can sample them at any time.
REQ-022 While en=0, samples SHALL NOT be accepted, o_valid and o_sync_err SHALL be 0, and wp, the shadow slots, the outputs and o_blk_cnt SHALL hold.
REQ-023 Gaps in i_valid SHALL NOT break a block; the samples accumulate across idle cycles.
REQ-024 o_blk_cnt SHALL wrap from 255 to 0, with no flag.
REQ-025 Samples SHALL pass unmodified: no scaling, rounding or sign-extension.
REQ-026 Back-to-back blocks (i_valid=1 continuously) SHALL be sustained with no stall: one block every 4 cycles, and o_valid every 4th cycle.

Reset
REQ-027 While rst=1 at a rising edge, all outputs, the shadow slots, wp and o_blk_cnt SHALL be set to 0, and o_valid and o_sync_err SHALL be 0; rst SHALL override en.
REQ-028 Reset asserted mid-block SHALL discard the partial block, and the first sample accepted after reset SHALL go to slot A.

Verification
REQ-029 The bench SHALL cover: after reset, 4 consecutive valid samples re=3,2,1,3 with im=0 -> one cycle after the 4th: o_reA..D=3,2,1,3, o_valid=1 for 1 cycle, o_blk_cnt=1.
REQ-030 The bench SHALL cover: the samples -128,127,-1,0 with i_valid toggling 1,0,1,0,... -> the block completes on the 4th valid sample, with values exact (signed extremes preserved).
REQ-031 The bench SHALL cover: 2 samples, then i_sof=1 with re=5 -> o_sync_err=1 for 1 cycle, outputs unchanged; then 3 more samples -> a block with o_reA=5.
REQ-032 The bench SHALL cover: en=0 for 3 cycles between the 2nd and 3rd samples -> state holds, and the block still completes after 4 accepted samples.
REQ-033 The bench SHALL cover: continuous 1024 valid samples -> 256 o_valid pulses spaced 4 cycles apart, with o_blk_cnt ending at 0 (wrap).
REQ-034 The bench SHALL cover: rst=1 for 1 cycle after 3 samples -> all outputs 0, and the next 4 samples form a block starting at slot A.
